// File: rtl/crank_pkg.sv
// crank_pkg: shared types and constants for the 60-2 crank wheel emulator
package crank_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} crank_state_t;
  localparam int CRANK_PERIOD_MIN = 4;
  localparam int CRANK_TEETH_TOTAL = 60;
  localparam int CRANK_TEETH_MISSING = 2;
  localparam int CRANK_TOOTH_W = 6;
endpackage

// File: rtl/counter_compare.sv
// counter_compare: free-running up counter with sync clear and terminal compare
module counter_compare #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         srst,
  input  logic         en,
  input  logic [W-1:0] dtop,
  output logic [W-1:0] cnt,
  output logic         hit
);
  // count up, clearing on srst so each phase starts at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (srst) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign hit = cnt == dtop;
endmodule

// File: rtl/d_ff_wide.sv
// d_ff_wide: enabled multi-bit register with async reset
module d_ff_wide #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // hold unless enabled
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: 60-2 crank trigger-wheel emulator with shadowed tooth period
module crank_wheel_gen
  import crank_pkg::*;
#(
  parameter int PERIOD_WIDTH = 24,
  parameter int TEETH_TOTAL = CRANK_TEETH_TOTAL,
  parameter int TEETH_MISSING = CRANK_TEETH_MISSING
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [PERIOD_WIDTH-1:0]  period_in,
  input  logic                     period_load,
  output logic                     wheel_out,
  output logic                     gap_marker,
  output logic [CRANK_TOOTH_W-1:0] tooth_num,
  output logic                     running,
  output logic                     period_err
);
  localparam int CW = PERIOD_WIDTH + 1;
  crank_state_t state;
  logic [PERIOD_WIDTH-1:0] shadow_period, active_period;
  logic shadow_valid, load_ok, start, last_tooth, tooth_start, hit, half, srst;
  logic [CW-1:0] cnt, dtop, p_x, h_x;
  assign p_x = {1'b0, active_period};
  assign h_x = p_x >> 1;
  assign load_ok = period_load & (period_in >= PERIOD_WIDTH'(CRANK_PERIOD_MIN));
  assign last_tooth = tooth_num == CRANK_TOOTH_W'(TEETH_TOTAL - TEETH_MISSING - 1);
  assign start = (state == IDLE) & ena & shadow_valid;
  assign tooth_start = start | (hit & ena & (((state == LOW) & ~last_tooth) | (state == GAP)));
  assign half = (state == GAP) & (cnt == p_x - 1'b1);
  assign srst = (state == IDLE) | hit;
  // terminal count per phase; odd periods give the spare cycle to LOW
  always_comb
    dtop = state == HIGH ? h_x - 1'b1 :
           state == LOW  ? p_x - h_x - 1'b1 :
           state == GAP  ? (p_x << 1) - 1'b1 : '0;
  counter_compare #(.W(CW)) u_phase (
    .clk(clk), .rst(rst), .srst(srst), .en(1'b1), .dtop(dtop), .cnt(cnt), .hit(hit)
  );
  d_ff_wide #(.W(PERIOD_WIDTH)) u_shadow (
    .clk(clk), .rst(rst), .en(load_ok), .d(period_in), .q(shadow_period)
  );
  d_ff_wide #(.W(PERIOD_WIDTH)) u_active (
    .clk(clk), .rst(rst), .en(tooth_start), .d(shadow_period), .q(active_period)
  );
  // wheel sequencer; stop is honoured only at tooth boundaries
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shadow_valid <= 1'b0;
      wheel_out <= 1'b0;
      gap_marker <= 1'b0;
      tooth_num <= '0;
      running <= 1'b0;
      period_err <= 1'b0;
    end else begin
      gap_marker <= 1'b0;
      period_err <= period_load & ~load_ok;
      if (load_ok) shadow_valid <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= HIGH;
          wheel_out <= 1'b1;
          running <= 1'b1;
          gap_marker <= 1'b1;
          tooth_num <= '0;
        end
        HIGH: if (hit) begin
          state <= LOW;
          wheel_out <= 1'b0;
        end
        LOW: if (hit) begin
          if (!ena) begin
            state <= IDLE;
            running <= 1'b0;
          end else if (last_tooth) begin
            state <= GAP;
            tooth_num <= tooth_num + 1'b1;
          end else begin
            state <= HIGH;
            wheel_out <= 1'b1;
            tooth_num <= tooth_num + 1'b1;
          end
        end
        GAP: begin
          if (half) tooth_num <= tooth_num + 1'b1;
          if (hit) begin
            if (!ena) begin
              state <= IDLE;
              running <= 1'b0;
            end else begin
              state <= HIGH;
              wheel_out <= 1'b1;
              gap_marker <= 1'b1;
              tooth_num <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_crank_wheel_gen.sv
// tb_crank_wheel_gen: directed table-driven bench for the crank wheel emulator
module tb_crank_wheel_gen;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, period_load = 1'b0;
  logic [23:0] period_in = '0;
  logic wheel_out, gap_marker, running, period_err;
  logic [5:0] tooth_num;
  int n_cmp = 0, n_bad = 0, cyc = 0;

  typedef struct {int p; int err;} load_vec_t;
  typedef struct {int p; int h; int l; int rev; int gl;} rev_vec_t;

  crank_wheel_gen dut (
    .clk(clk), .rst(rst), .ena(ena), .period_in(period_in), .period_load(period_load),
    .wheel_out(wheel_out), .gap_marker(gap_marker), .tooth_num(tooth_num),
    .running(running), .period_err(period_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b0;
    period_load = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic load(input int p);
    period_in = 24'(p);
    period_load = 1'b1;
    step();
    period_load = 1'b0;
  endtask

  task automatic wait_tooth(input int t);
    int i;
    for (i = 0; i < 20000 && tooth_num != 6'(t); i++) step();
    if (tooth_num != 6'(t)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_tooth%0d: got %0d want %0d", t, tooth_num, t);
    end
  endtask

  task automatic tooth_len(output int len);
    logic [5:0] t;
    t = tooth_num;
    len = 0;
    while (tooth_num == t && len < 1000) begin
      step();
      len++;
    end
  endtask

  task automatic run_rev(input rev_vec_t v);
    int hi_len, first_lo, last_lo, lo_run, rises, rev;
    logic prev, in_first;
    do_reset();
    load(v.p);
    ena = 1'b1;
    step();
    chk($sformatf("start_p%0d", v.p), {wheel_out, running, gap_marker}, 3'b111);
    hi_len = 1; first_lo = -1; last_lo = 0; lo_run = 0; rises = 0; rev = 0;
    prev = 1'b1; in_first = 1'b1;
    for (int c = 1; c <= 60 * v.p + 5; c++) begin
      step();
      if (c == 58 * v.p) chk($sformatf("tooth58_p%0d", v.p), tooth_num, 58);
      if (c == 59 * v.p) chk($sformatf("tooth59_p%0d", v.p), tooth_num, 59);
      if (wheel_out && !prev) begin
        rises++;
        if (first_lo < 0) first_lo = lo_run;
        last_lo = lo_run;
      end
      lo_run = wheel_out ? 0 : lo_run + 1;
      if (in_first) begin
        if (wheel_out) hi_len++;
        else in_first = 1'b0;
      end
      prev = wheel_out;
      if (gap_marker) begin
        rev = c;
        break;
      end
    end
    chk($sformatf("rev_p%0d", v.p), rev, v.rev);
    chk($sformatf("rises_p%0d", v.p), rises, 58);
    chk($sformatf("high_p%0d", v.p), hi_len, v.h);
    chk($sformatf("low_p%0d", v.p), first_lo, v.l);
    chk($sformatf("gaplow_p%0d", v.p), last_lo, v.gl);
  endtask

  initial begin
    load_vec_t lv[5];
    rev_vec_t rv[4];
    int s, len, hi;
    lv[0] = '{3, 1};
    lv[1] = '{0, 1};
    lv[2] = '{1, 1};
    lv[3] = '{4, 0};
    lv[4] = '{24'hFFFFFF, 0};
    rv[0] = '{8, 4, 4, 480, 20};
    rv[1] = '{9, 4, 5, 540, 23};
    rv[2] = '{4, 2, 2, 240, 10};
    rv[3] = '{5, 2, 3, 300, 13};

    do_reset();
    chk("reset_out", {wheel_out, gap_marker, running, period_err, tooth_num}, 0);

    for (int i = 0; i < 5; i++) begin
      period_in = 24'(lv[i].p);
      period_load = 1'b1;
      step();
      period_load = 1'b0;
      chk($sformatf("err_pulse_%0d", lv[i].p), period_err, lv[i].err);
      step();
      chk($sformatf("err_clear_%0d", lv[i].p), period_err, 0);
    end

    for (int i = 0; i < 4; i++) run_rev(rv[i]);

    do_reset();
    ena = 1'b1;
    period_in = 24'd3;
    period_load = 1'b1;
    step();
    period_load = 1'b0;
    chk("err_p3", period_err, 1);
    repeat (20) step();
    chk("idle_p3", running, 0);
    load(8);
    load(3);
    chk("err_p3_run", period_err, 1);
    wait_tooth(1);
    tooth_len(len);
    chk("shadow_kept", len, 8);

    do_reset();
    load(8);
    period_in = 24'd12;
    period_load = 1'b1;
    ena = 1'b1;
    step();
    period_load = 1'b0;
    chk("start_with_load", {running, gap_marker}, 2'b11);
    tooth_len(len);
    chk("start_old_shadow", len, 8);
    tooth_len(len);
    chk("start_new_next", len, 12);

    do_reset();
    period_in = 24'd8;
    period_load = 1'b1;
    ena = 1'b1;
    step();
    period_load = 1'b0;
    chk("nostart_noshadow", running, 0);
    step();
    chk("start_delayed", {running, gap_marker}, 2'b11);

    do_reset();
    load(100);
    ena = 1'b1;
    wait_tooth(10);
    s = cyc;
    repeat (10) step();
    load(200);
    tooth_len(len);
    chk("tooth10_len", cyc - s, 100);
    tooth_len(len);
    chk("tooth11_len", len, 200);

    do_reset();
    load(100);
    ena = 1'b1;
    wait_tooth(57);
    repeat (99) step();
    load(200);
    s = cyc;
    for (int i = 0; i < 1000 && (tooth_num == 58 || tooth_num == 59); i++) step();
    chk("gap_len_old", cyc - s, 200);
    chk("gap_marker_t0", gap_marker, 1);
    tooth_len(len);
    chk("tooth0_new", len, 200);

    do_reset();
    load(8);
    ena = 1'b1;
    wait_tooth(20);
    s = cyc;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      if (wheel_out) hi++;
      if (cyc == s + 1) ena = 1'b0;
      if (!running) break;
      step();
    end
    chk("stop_high", hi, 4);
    chk("stop_at_boundary", cyc - s, 8);
    chk("stop_tooth_hold", tooth_num, 20);
    chk("stop_wheel", wheel_out, 0);

    do_reset();
    load(8);
    ena = 1'b1;
    wait_tooth(58);
    step();
    step();
    #2 rst = 1'b1;
    #1 chk("async_rst", {wheel_out, gap_marker, running, period_err, tooth_num}, 0);
    step();
    rst = 1'b0;
    step();
    chk("rst_clears_shadow", running, 0);
    load(8);
    step();
    chk("restart", {running, gap_marker, wheel_out, tooth_num}, {3'b111, 6'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
